// File: rtl/score_counter.sv
// Score counter: two debounced push-buttons (+1 / -1), a hit input (+HIT_POINTS)
// and a synchronous clear. The score saturates at 0 and MAX_VALUE.
module score_counter #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned MAX_VALUE       = 999,
    parameter int unsigned HIT_POINTS      = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_inc_n,
    input  logic       key_dec_n,
    input  logic       hit,
    input  logic       clear,
    output logic [9:0] valor,
    output logic       at_max,
    output logic       changed
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam int unsigned SUM_W = 12;
    localparam logic signed [SUM_W-1:0] HIT_S = SUM_W'(HIT_POINTS);
    localparam logic signed [SUM_W-1:0] MAX_S = SUM_W'(MAX_VALUE);
    localparam logic [9:0] MAX_V = 10'(MAX_VALUE);

    typedef enum logic [1:0] {StRel, StChkPrs, StPrs, StChkRel} deb_state_e;

    // Index 0 is the increment key, index 1 the decrement key.
    logic [1:0] keys_n;
    logic [1:0] press_evt;

    assign keys_n = {key_dec_n, key_inc_n};

    for (genvar k = 0; k < 2; k++) begin : g_key
        logic             sync1_q;
        logic             sync2_q;
        deb_state_e       state_q;
        logic [CNT_W-1:0] cnt_q;
        logic             evt_q;

        // Two-flop synchronizer; idles high (released) out of reset
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync1_q <= 1'b1;
                sync2_q <= 1'b1;
            end else begin
                sync1_q <= keys_n[k];
                sync2_q <= sync1_q;
            end
        end

        // Debounce FSM; emits a registered one-cycle pulse only on an accepted press
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= StRel;
                cnt_q   <= '0;
                evt_q   <= 1'b0;
            end else begin
                evt_q <= 1'b0;
                case (state_q)
                    StRel: begin
                        if (!sync2_q) begin
                            state_q <= StChkPrs;
                            cnt_q   <= '0;
                        end
                    end
                    StChkPrs: begin
                        if (sync2_q) begin
                            state_q <= StRel;
                        end else if (cnt_q == CNT_LAST) begin
                            state_q <= StPrs;
                            evt_q   <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    StPrs: begin
                        if (sync2_q) begin
                            state_q <= StChkRel;
                            cnt_q   <= '0;
                        end
                    end
                    StChkRel: begin
                        if (!sync2_q) begin
                            state_q <= StPrs;
                        end else if (cnt_q == CNT_LAST) begin
                            state_q <= StRel;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    default: state_q <= StRel;
                endcase
            end
        end

        assign press_evt[k] = evt_q;
    end

    logic signed [SUM_W-1:0] sum;
    logic [9:0]              valor_d;
    logic [9:0]              valor_q;
    logic                    at_max_q;
    logic                    changed_q;

    // Sum all events in wide signed arithmetic, then saturate; clear overrides everything
    always_comb begin
        sum = $signed({2'b00, valor_q})
            + (hit ? HIT_S : '0)
            + (press_evt[0] ? SUM_W'(1) : '0)
            - (press_evt[1] ? SUM_W'(1) : '0);
        if (clear) begin
            valor_d = '0;
        end else if (sum[SUM_W-1]) begin
            valor_d = '0;
        end else if (sum > MAX_S) begin
            valor_d = MAX_V;
        end else begin
            valor_d = sum[9:0];
        end
    end

    // Score register; flags are computed from the next value so they line up with valor
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valor_q   <= '0;
            at_max_q  <= 1'b0;
            changed_q <= 1'b0;
        end else begin
            valor_q   <= valor_d;
            at_max_q  <= (valor_d == MAX_V);
            changed_q <= (valor_d != valor_q);
        end
    end

    assign valor   = valor_q;
    assign at_max  = at_max_q;
    assign changed = changed_q;

endmodule

// File: tb/tb_score_counter.sv
// Self-checking bench for score_counter: directed scenarios plus random stimulus,
// compared every cycle against a behavioural model of the score rules.
module tb_score_counter;

    localparam int D    = 4;
    localparam int MAXV = 999;
    localparam int HP   = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_inc_n = 1'b1;
    logic       key_dec_n = 1'b1;
    logic       hit = 1'b0;
    logic       clear = 1'b0;
    logic [9:0] valor;
    logic       at_max;
    logic       changed;

    score_counter #(
        .DEBOUNCE_CYCLES(D),
        .MAX_VALUE      (MAXV),
        .HIT_POINTS     (HP)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .key_inc_n(key_inc_n),
        .key_dec_n(key_dec_n),
        .hit      (hit),
        .clear    (clear),
        .valor    (valor),
        .at_max   (at_max),
        .changed  (changed)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: score, flags, per-key synchronizer delay, debounced level and
    // run length of samples disagreeing with it, plus the pending press event.
    int m_valor   = 0;
    int m_at_max  = 0;
    int m_changed = 0;
    bit s1[2];
    bit s2[2];
    bit deb[2];
    int run[2];
    bit evt[2];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // One rising edge of the reference model, inputs as currently driven
    task automatic model_step();
        bit raw[2];
        int nv;
        raw[0] = key_inc_n;
        raw[1] = key_dec_n;
        if (!rst_n) begin
            m_valor = 0; m_at_max = 0; m_changed = 0;
            for (int k = 0; k < 2; k++) begin
                s1[k] = 1; s2[k] = 1; deb[k] = 1; run[k] = 0; evt[k] = 0;
            end
            return;
        end
        nv = m_valor + (hit ? HP : 0) + (evt[0] ? 1 : 0) - (evt[1] ? 1 : 0);
        if (nv < 0) nv = 0;
        if (nv > MAXV) nv = MAXV;
        if (clear) nv = 0;
        m_changed = (nv != m_valor);
        m_at_max  = (nv == MAXV);
        m_valor   = nv;
        // A new level is accepted once it has been seen for D+1 consecutive
        // synchronized samples (the first one starts the check window).
        for (int k = 0; k < 2; k++) begin
            evt[k] = 0;
            if (s2[k] != deb[k]) begin
                run[k]++;
                if (run[k] == D + 1) begin
                    deb[k] = s2[k];
                    run[k] = 0;
                    evt[k] = (s2[k] == 1'b0);
                end
            end else begin
                run[k] = 0;
            end
            s2[k] = s1[k];
            s1[k] = raw[k];
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_eq("valor", 32'(valor), 32'(m_valor));
        check_eq("at_max", 32'(at_max), 32'(m_at_max));
        check_eq("changed", 32'(changed), 32'(m_changed));
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic press_inc();
        key_inc_n = 1'b0;
        cycles(10);
        key_inc_n = 1'b1;
        cycles(10);
    endtask

    int first_edge;
    int pulses;

    initial begin
        cycles(2);
        rst_n = 1'b1;
        cycles(2);
        check_eq("reset_valor", 32'(valor), 32'd0);

        // Scenario 1: held inc key gives exactly one +1, 7 edges after first sample
        key_inc_n = 1'b0;
        first_edge = -1;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (changed) pulses++;
            if (valor == 10'd1 && first_edge < 0) first_edge = i;
        end
        check_eq("s1_latency", 32'(first_edge), 32'd7);
        check_eq("s1_pulses", 32'(pulses), 32'd1);
        check_eq("s1_valor", 32'(valor), 32'd1);
        key_inc_n = 1'b1;
        cycles(10);

        // Scenario 2: glitch rejected, then stable dec at zero stays zero
        clear = 1'b1; cycle(); clear = 1'b0;
        pulses = 0;
        key_dec_n = 1'b0; cycles(3); key_dec_n = 1'b1;
        for (int i = 0; i < 10; i++) begin cycle(); if (changed) pulses++; end
        key_dec_n = 1'b0;
        for (int i = 0; i < 12; i++) begin cycle(); if (changed) pulses++; end
        key_dec_n = 1'b1;
        cycles(8);
        check_eq("s2_valor", 32'(valor), 32'd0);
        check_eq("s2_pulses", 32'(pulses), 32'd0);

        // Scenario 3: saturation at MAX_VALUE
        hit = 1'b1; cycles(99); hit = 1'b0;
        for (int i = 0; i < 5; i++) press_inc();
        check_eq("s3_995", 32'(valor), 32'd995);
        hit = 1'b1; cycle(); hit = 1'b0;
        check_eq("s3_999", 32'(valor), 32'd999);
        check_eq("s3_at_max", 32'(at_max), 32'd1);
        hit = 1'b1; cycle(); hit = 1'b0;
        check_eq("s3_sat_valor", 32'(valor), 32'd999);
        check_eq("s3_sat_changed", 32'(changed), 32'd0);

        // Scenario 4: hit and dec event in the same cycle, then clear beats hit
        clear = 1'b1; cycle(); clear = 1'b0;
        hit = 1'b1; cycles(5); hit = 1'b0;
        check_eq("s4_50", 32'(valor), 32'd50);
        key_dec_n = 1'b0;
        cycles(7);
        hit = 1'b1; cycle(); hit = 1'b0;
        check_eq("s4_59", 32'(valor), 32'd59);
        cycles(3);
        key_dec_n = 1'b1;
        cycles(10);
        hit = 1'b1; clear = 1'b1; cycle(); hit = 1'b0; clear = 1'b0;
        check_eq("s4_clear", 32'(valor), 32'd0);
        cycles(2);

        // Scenario 5: reset mid-debounce abandons the pending press
        key_inc_n = 1'b0;
        cycles(3);
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        first_edge = -1;
        for (int i = 0; i < 15; i++) begin
            cycle();
            if (valor == 10'd1 && first_edge < 0) first_edge = i;
        end
        check_eq("s5_latency", 32'(first_edge), 32'd7);
        check_eq("s5_valor", 32'(valor), 32'd1);
        key_inc_n = 1'b1;
        cycles(10);

        // Random phase: glitchy keys, hits and clears; dense hits in the second half
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) key_inc_n = ~key_inc_n;
            if ($urandom_range(0, 7) == 0) key_dec_n = ~key_dec_n;
            hit   = (i < 1500) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 1) == 0);
            clear = ($urandom_range(0, 99) == 0);
            rst_n = ($urandom_range(0, 499) != 0);
            cycle();
        end
        rst_n = 1'b1; hit = 1'b0; clear = 1'b0;
        cycles(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
